// File: rtl/atomrvcore_imem.sv
// Instruction-memory responder for the atomRVCORE fetch unit: valid/ready fetch
// requests, fixed wait states, word-organised store with a write-only load port.
module atomrvcore_imem #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 1024,
    parameter int WAIT      = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [DATAWIDTH-1:0] req_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATAWIDTH-1:0] rsp_instr_o,
    output logic                 rsp_err_o,
    input  logic                 load_en_i,
    input  logic [DATAWIDTH-1:0] load_addr_i,
    input  logic [DATAWIDTH-1:0] load_data_i,
    output logic                 busy_o
);

    localparam int                   IDX_W     = $clog2(DEPTH);
    localparam logic [3:0]           WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
    localparam bit                   ZERO_WAIT = (WAIT == 0);
    localparam logic [DATAWIDTH-1:0] NOP       = DATAWIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           cnt;
    logic [DATAWIDTH-1:0] addr_q;
    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic                 ready;
    logic                 accept;
    logic                 capture;
    logic [DATAWIDTH-1:0] cap_addr;
    logic                 unused_load_lsb;

    function automatic logic beyond_depth(input logic [DATAWIDTH-1:0] a);
        return a[DATAWIDTH-1:IDX_W+2] != '0;
    endfunction

    function automatic logic fetch_fault(input logic [DATAWIDTH-1:0] a);
        return (a[1:0] != 2'b00) || beyond_depth(a);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [DATAWIDTH-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    assign unused_load_lsb = ^load_addr_i[1:0];

    always_comb begin
        ready     = 1'b0;
        state_nxt = state;
        case (state)
            S_IDLE:  ready = !load_en_i;
            S_RESP:  ready = rsp_ready_i && !load_en_i;
            default: ready = 1'b0;
        endcase
        accept = req_valid_i && ready;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = ZERO_WAIT ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) state_nxt = accept ? (ZERO_WAIT ? S_RESP : S_WAIT) : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // With no wait states the response is captured on the accept edge itself,
        // so the incoming address is used before it has been latched.
        capture  = (accept && ZERO_WAIT) || ((state == S_WAIT) && (cnt == 4'd0));
        cap_addr = accept ? req_addr_i : addr_q;
    end

    assign req_ready_o = ready;
    assign rsp_valid_o = (state == S_RESP);
    assign busy_o      = (state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= WAIT_INIT;
            end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) addr_q <= req_addr_i;
    end

    // Read and write share an edge; the nonblocking write makes capture see the old word.
    always_ff @(posedge clk_i) begin
        if (load_en_i && !beyond_depth(load_addr_i)) begin
            mem[word_idx(load_addr_i)] <= load_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_instr_o <= '0;
            rsp_err_o   <= 1'b0;
        end else if (capture) begin
            if (fetch_fault(cap_addr)) begin
                rsp_instr_o <= NOP;
                rsp_err_o   <= 1'b1;
            end else begin
                rsp_instr_o <= mem[word_idx(cap_addr)];
                rsp_err_o   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_atomrvcore_imem.sv
// Scoreboard bench for atomrvcore_imem: three instances (WAIT 0/1/3) share the
// load port; one is selected at a time for fetch traffic.
module tb_atomrvcore_imem;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic [1:0]  sel;

    wire  [2:0]  rr_w;
    wire  [2:0]  rv_w;
    wire  [2:0]  re_w;
    wire  [2:0]  bz_w;
    wire  [31:0] ri_w [3];

    wire         s_req_ready = rr_w[sel];
    wire         s_rsp_valid = rv_w[sel];
    wire         s_rsp_err   = re_w[sel];
    wire         s_busy      = bz_w[sel];
    wire  [31:0] s_rsp_instr = ri_w[sel];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [32:0] exp_q [$];
    int          acc_q [$];
    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    atomrvcore_imem #(.DATAWIDTH(32), .DEPTH(DEPTH), .WAIT(0)) u_w0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid && (sel == 2'd0)), .req_ready_o(rr_w[0]), .req_addr_i(req_addr),
        .rsp_valid_o(rv_w[0]), .rsp_ready_i(rsp_ready && (sel == 2'd0)),
        .rsp_instr_o(ri_w[0]), .rsp_err_o(re_w[0]),
        .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data), .busy_o(bz_w[0])
    );

    atomrvcore_imem #(.DATAWIDTH(32), .DEPTH(DEPTH), .WAIT(1)) u_w1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid && (sel == 2'd1)), .req_ready_o(rr_w[1]), .req_addr_i(req_addr),
        .rsp_valid_o(rv_w[1]), .rsp_ready_i(rsp_ready && (sel == 2'd1)),
        .rsp_instr_o(ri_w[1]), .rsp_err_o(re_w[1]),
        .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data), .busy_o(bz_w[1])
    );

    atomrvcore_imem #(.DATAWIDTH(32), .DEPTH(DEPTH), .WAIT(3)) u_w3 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid && (sel == 2'd2)), .req_ready_o(rr_w[2]), .req_addr_i(req_addr),
        .rsp_valid_o(rv_w[2]), .rsp_ready_i(rsp_ready && (sel == 2'd2)),
        .rsp_instr_o(ri_w[2]), .rsp_err_o(re_w[2]),
        .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data), .busy_o(bz_w[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int wait_of(input logic [1:0] s);
        return (s == 2'd0) ? 0 : ((s == 2'd1) ? 1 : 3);
    endfunction

    function automatic logic [32:0] expect_rsp(input logic [31:0] a);
        if ((a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH))) return {1'b1, 32'h0000_0013};
        return {1'b0, model_mem[a[5:2]]};
    endfunction

    // Monitor: pops/compares on response handshakes, pushes on request accepts.
    initial begin
        logic        prev_pending;
        logic [31:0] prev_instr;
        logic        prev_err;
        int          vstart;
        logic [32:0] e;
        int          a;
        prev_pending = 1'b0;
        prev_instr   = '0;
        prev_err     = 1'b0;
        vstart       = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_pending = 1'b0;
            end else begin
                if (s_rsp_valid) begin
                    if (!prev_pending) begin
                        vstart = cyc;
                    end else begin
                        chk("hold_instr", s_rsp_instr, prev_instr);
                        chk("hold_err", s_rsp_err, prev_err);
                    end
                    if (rsp_ready) begin
                        chk("rsp_expected", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            a = acc_q.pop_front();
                            chk("rsp_instr", s_rsp_instr, e[31:0]);
                            chk("rsp_err", s_rsp_err, e[32]);
                            chk("latency", vstart - a, wait_of(sel) + 1);
                        end
                        prev_pending = 1'b0;
                    end else begin
                        chk("stall_req_ready", s_req_ready, 0);
                        prev_pending = 1'b1;
                        prev_instr   = s_rsp_instr;
                        prev_err     = s_rsp_err;
                    end
                end else begin
                    prev_pending = 1'b0;
                end
                if (req_valid && s_req_ready) begin
                    exp_q.push_back(expect_rsp(req_addr));
                    acc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        if (a[31:2] < 30'(DEPTH)) model_mem[a[5:2]] = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        int n;
        n         = 0;
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        while (!s_req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept", s_req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n         = 0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        sel       = 2'd1;
        repeat (3) step();
        rst = 1'b0;

        // Reset state of every instance
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            @(negedge clk);
            chk("rst_rsp_valid", s_rsp_valid, 0);
            chk("rst_rsp_instr", s_rsp_instr, 0);
            chk("rst_rsp_err", s_rsp_err, 0);
            chk("rst_busy", s_busy, 0);
            chk("rst_req_ready", s_req_ready, 1);
        end
        step();

        do_load(32'h0, 32'h0050_0093);
        do_load(32'h4, 32'h00A0_0113);
        do_load(32'h8, 32'h0020_81B3);
        do_load(32'hC, 32'h0000_006F);

        // WAIT=1 basic fetch
        sel = 2'd1;
        rsp_ready = 1'b1;
        fetch(32'h0);
        drain();

        // Load blocks acceptance; out-of-range load must not alias onto word 0
        req_valid = 1'b1;
        req_addr  = 32'h4;
        load_en   = 1'b1;
        load_addr = 32'h40;
        load_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("load_blocks_ready", s_req_ready, 0);
        step();
        load_en   = 1'b0;
        req_valid = 1'b0;
        chk("load_no_accept", exp_q.size(), 0);
        fetch(32'h0);
        drain();

        do_load(32'h8, 32'h1234_5678);
        fetch(32'h8);
        drain();

        // Same-edge load to the word under capture returns the old value
        req_valid = 1'b1;
        req_addr  = 32'hC;
        @(negedge clk);
        chk("se_accept", s_req_ready, 1);
        step();
        req_valid = 1'b0;
        load_en   = 1'b1;
        load_addr = 32'hC;
        load_data = 32'hCAFE_F00D;
        model_mem[3] = 32'hCAFE_F00D;
        step();
        load_en = 1'b0;
        drain();
        fetch(32'hC);
        drain();

        // Fault responses
        fetch(32'h6);
        drain();
        fetch(32'(DEPTH * 4));
        drain();

        // Backpressure: response held while consumer stalls, then release with a new accept
        rsp_ready = 1'b0;
        fetch(32'h4);
        req_valid = 1'b1;
        req_addr  = 32'h0;
        repeat (6) step();
        chk("stall_valid", s_rsp_valid, 1);
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        drain();

        // WAIT=0 back-to-back throughput
        sel       = 2'd0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'(i * 4);
            @(negedge clk);
            chk("tput_ready", s_req_ready, 1);
            if (i > 0) chk("tput_valid", s_rsp_valid, 1);
            step();
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("tput_valid", s_rsp_valid, 1);
        step();
        drain();
        fetch(32'h6);
        drain();

        // WAIT=3: reset mid-wait drops the fetch
        sel = 2'd2;
        fetch(32'h4);
        step();
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_rsp_valid", s_rsp_valid, 0);
        chk("rstw_busy", s_busy, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            chk("rstw_no_rsp", s_rsp_valid, 0);
        end
        step();
        fetch(32'h8);
        drain();

        chk("final_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/atomrvcore_imem.md
# atomrvcore_imem

Instruction-memory responder for the fetch side of atomRVCORE. Accepts byte-address fetch requests from the instruction fetch unit over a valid/ready handshake, reads a word-organised instruction store after a programmable number of wait states, and returns the 32-bit instruction with an error flag over a second valid/ready handshake. A write-only load port preloads the program before or between fetches.

## Interface
Parameters:
- DATAWIDTH, 32, instruction/data word width (fixed at 32 for RV32)
- DEPTH, 1024, number of instruction words; power of two, 16..65536
- WAIT, 1, wait states per fetch, 0..15

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  fetch request valid
- req_ready_o  out  1  fetch request accepted this cycle when high with req_valid_i
- req_addr_i  in  DATAWIDTH  fetch byte address (PC)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_instr_o  out  DATAWIDTH  fetched instruction
- rsp_err_o  out  1  fetch fault (misaligned or out of range)
- load_en_i  in  1  program-load write strobe
- load_addr_i  in  DATAWIDTH  load byte address; bits [1:0] ignored
- load_data_i  in  DATAWIDTH  load word
- busy_o  out  1  high in any state other than IDLE

## Operation
- Clock is clk_i; reset is rst_i, synchronous, active-high.
- Storage: DEPTH x 32 array, word index = addr[log2(DEPTH)+1:2]. Contents not reset.
- FSM states IDLE, WAIT, RESP.
  - IDLE: req_ready_o = !load_en_i. On accept: latch req_addr_i; WAIT==0 -> RESP next cycle; else load counter with WAIT-1, -> WAIT.
  - WAIT: req_ready_o=0; counter decrements each cycle; at counter==0 -> RESP.
  - RESP: rsp_valid_o=1; rsp_instr_o/rsp_err_o held stable until rsp_ready_i. On rsp_ready_i: if req_valid_i && req_ready_o, accept new request (same rules as IDLE: -> RESP if WAIT==0, else WAIT); otherwise -> IDLE.
  - req_ready_o in RESP = rsp_ready_i && !load_en_i (supports 1 fetch/cycle when WAIT==0).
- Response register loaded on the edge entering RESP, from the latched address:
  - addr[1:0]!=0 -> rsp_err_o=1, rsp_instr_o=32'h0000_0013 (NOP).
  - addr[31:2] >= DEPTH -> rsp_err_o=1, rsp_instr_o=32'h0000_0013.
  - otherwise rsp_err_o=0, rsp_instr_o=mem[index].
- Load port: load_en_i writes mem[load_addr_i index] <= load_data_i every cycle it is high, in any state; out-of-range load addresses are dropped silently. Load never stalls an in-flight fetch, only blocks acceptance.
- Same-edge load and response capture to the same word: response gets the old word (read-before-write).
- Request address/valid are sampled only on the accept edge; changes afterwards have no effect.

## Timing
- Reset values: state IDLE, rsp_valid_o=0, rsp_instr_o=0, rsp_err_o=0, busy_o=0, counter=0; req_ready_o=!load_en_i after reset.
- Reset mid-fetch (WAIT or RESP): transaction discarded, no response issued.
- Latency accept -> rsp_valid_o: WAIT+1 cycles.
- Throughput: WAIT==0 with rsp_ready_i held high -> one response per cycle; WAIT=N -> one per N+1 cycles minimum.
- rsp_valid_o, once high, stays high with stable data until rsp_ready_i is sampled high.
- No combinational path from req_* to rsp_*; req_ready_o depends combinationally only on state, rsp_ready_i, load_en_i.

## Test plan
- Load mem[0..3]=32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F; WAIT=1; fetch 0x0 -> rsp_valid_o 2 cycles after accept, rsp_instr_o=32'h00500093, rsp_err_o=0.
- WAIT=0, req_valid_i and rsp_ready_i held high, addresses 0x0,0x4,0x8,0xC -> four consecutive responses on four consecutive cycles, matching loaded words in order.
- Fetch 0x6 and fetch DEPTH*4 -> rsp_err_o=1, rsp_instr_o=32'h00000013 each.
- Response with rsp_ready_i low for 5 cycles -> rsp_valid_o and data stable all 5 cycles; req_ready_o=0 throughout; single handshake on release.
- load_en_i high while req_valid_i high in IDLE -> req_ready_o=0, no accept; load word visible to a subsequent fetch; same-edge load to word under capture returns the old value.
- rst_i asserted during WAIT with WAIT=3 -> next cycle rsp_valid_o=0, busy_o=0, no response for the dropped fetch; new fetch then completes normally.
